dm_access_unit: RTL and testbench

//  Memory-side consumer of the decoder's MemWrite/DMType controls: takes one load/store request per handshake,

---
 rtl/dm_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// dm_access_unit: load/store unit between EX/MEM and a word-addressed data bus.
// Accepts one request per handshake. The request is issued as one or two bus beats,
// and the unit then returns a single response pulse.
// Optional feature macro: MISALIGN_SPLIT_EN.
//   - Defined: a misaligned half/word access is split into two bus beats.
//   - Undefined: a misaligned half/word access is rejected with an error response.
module dm_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_dmtype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t state, state_next;

    logic             we_q;
    logic [2:0]       dmtype_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata0_q;
    logic [31:0]      rdata1_q;
    logic             err_q;
    logic             split_q;
    logic [CNT_W-1:0] cnt;

    logic             timeout_hit;
    logic             timeout_fire;
    logic             req_illegal;
    logic             req_misaligned;
    logic             decode_err;
    logic [7:0]       be_wide;
    logic [63:0]      wdata_wide;
    logic [63:0]      load_wide;
    logic [31:0]      load_data;

    // Byte-lane mask for the access size; stores with unsigned types use the signed size.
    function automatic logic [3:0] size_mask(input logic [2:0] t);
        case (t)
            3'b000:         size_mask = 4'b1111;
            3'b001, 3'b010: size_mask = 4'b0011;
            default:        size_mask = 4'b0001;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
        case (t)
            3'b000:         is_misaligned = (off != 2'b00);
            3'b001, 3'b010: is_misaligned = off[0];
            default:        is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] w);
        case (t)
            3'b000:  extend = w;
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b010:  extend = {16'h0000, w[15:0]};
            3'b011:  extend = {{24{w[7]}}, w[7:0]};
            default: extend = {24'h000000, w[7:0]};
        endcase
    endfunction

    assign req_illegal    = (req_dmtype > 3'b100);
    assign req_misaligned = is_misaligned(req_dmtype, req_addr[1:0]);
    assign decode_err     = req_illegal || (req_misaligned && !SPLIT_EN);
    assign timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1));

    // A two-word lane window: the low half feeds beat 0, the high half feeds beat 1.
    assign be_wide    = {4'b0000, size_mask(dmtype_q)} << addr_q[1:0];
    assign wdata_wide = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign load_wide  = {rdata1_q, rdata0_q} >> {addr_q[1:0], 3'b000};
    assign load_data  = extend(dmtype_q, load_wide[31:0]);

    // State register; reset abandons any outstanding beat without responding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and bus/response outputs.
    always_comb begin
        state_next   = state;
        timeout_fire = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = 32'h0;
        rsp_err      = 1'b0;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = 32'h0;
        bus_be       = 4'b0000;
        bus_wdata    = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = decode_err ? RESP : REQ0;
            end
            REQ0: begin
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_be    = be_wide[3:0];
                bus_wdata = wdata_wide[31:0];
                if (bus_gnt) state_next = WAIT0;
                else if (timeout_hit) begin
                    state_next   = RESP;
                    timeout_fire = 1'b1;
                end
            end
            WAIT0: begin
                if (bus_rvalid) state_next = split_q ? REQ1 : RESP;
                else if (timeout_hit) begin
                    state_next   = RESP;
                    timeout_fire = 1'b1;
                end
            end
            REQ1: begin
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                bus_be    = be_wide[7:4];
                bus_wdata = wdata_wide[63:32];
                if (bus_gnt) state_next = WAIT1;
                else if (timeout_hit) begin
                    state_next   = RESP;
                    timeout_fire = 1'b1;
                end
            end
            WAIT1: begin
                if (bus_rvalid) state_next = RESP;
                else if (timeout_hit) begin
                    state_next   = RESP;
                    timeout_fire = 1'b1;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_q;
                rsp_rdata  = (err_q || we_q) ? 32'h0 : load_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, beat capture and per-beat timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            dmtype_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q     <= req_we;
                dmtype_q <= req_dmtype;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata0_q <= 32'h0;
                rdata1_q <= 32'h0;
                err_q    <= decode_err;
                split_q  <= req_misaligned && SPLIT_EN;
            end
            if (timeout_fire) err_q <= 1'b1;
            if (state == WAIT0 && bus_rvalid) rdata0_q <= bus_rdata;
            if (state == WAIT1 && bus_rvalid) rdata1_q <= bus_rdata;
            if ((state_next == REQ0 && state != REQ0) || (state_next == REQ1 && state != REQ1))
                cnt <= '0;
            else if (state inside {REQ0, WAIT0, REQ1, WAIT1})
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed testbench for dm_access_unit. The MISALIGN_SPLIT_EN macro selects
// which behaviour the misalignment test expects.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_dmtype = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent transaction
    int          obs_nbeat;
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be [2];
    logic [31:0] obs_wdata [2];
    logic        obs_we;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_rsp;
    logic        obs_req_at_rsp;
    int          obs_req_cycles;
    logic        obs_ready_busy;

    dm_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Issue one request and play a bus that grants immediately and completes the
    // following cycle. Records what it sees; performs no checks itself.
    task automatic xact(input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd0,
                        input logic [31:0] rd1, input bit gnt_en);
        logic [31:0] rd [2];
        bit pending;
        rd[0] = rd0; rd[1] = rd1; pending = 0;
        obs_nbeat = 0; obs_we = 0; obs_lat = 0; obs_rdata = 32'hDEADDEAD; obs_err = 0;
        obs_rsp = 0; obs_req_at_rsp = 0; obs_req_cycles = 0; obs_ready_busy = 0;
        for (int i = 0; i < 2; i++) begin
            obs_addr[i] = 32'hX; obs_be[i] = 4'hX; obs_wdata[i] = 32'hX;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_dmtype = t; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 60 && !obs_rsp; c++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (rsp_valid) begin
                obs_rsp = 1; obs_lat = c; obs_rdata = rsp_rdata; obs_err = rsp_err;
                obs_req_at_rsp = bus_req;
            end else begin
                if (req_ready) obs_ready_busy = 1;
                if (pending) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rd[(obs_nbeat - 1) & 1];
                    pending    = 0;
                end
                if (bus_req) begin
                    obs_req_cycles++;
                    if (gnt_en) begin
                        if (obs_nbeat < 2) begin
                            obs_addr[obs_nbeat]  = bus_addr;
                            obs_be[obs_nbeat]    = bus_be;
                            obs_wdata[obs_nbeat] = bus_wdata;
                        end
                        obs_we = bus_we;
                        bus_gnt = 1'b1;
                        obs_nbeat++;
                        pending = 1;
                    end
                end
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if ({rsp_rdata, rsp_err, bus_we, bus_addr, bus_be, bus_wdata} !== 102'h0) begin
            errors++; $display("FAIL reset_outputs got rdata %h err %b we %b addr %h be %b wdata %h exp all 0",
                               rsp_rdata, rsp_err, bus_we, bus_addr, bus_be, bus_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        xact(1'b0, 3'b000, 32'h100, 32'h0, 32'h8899AABB, 32'h0, 1);
        checks++; if (obs_rsp !== 1'b1) begin errors++; $display("FAIL lw_rsp got %b exp 1", obs_rsp); end
        checks++; if (obs_nbeat != 1) begin errors++; $display("FAIL lw_beats got %0d exp 1", obs_nbeat); end
        checks++; if (obs_addr[0] !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", obs_addr[0]); end
        checks++; if (obs_be[0] !== 4'b1111) begin errors++; $display("FAIL lw_be got %b exp 1111", obs_be[0]); end
        checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL lw_we got %b exp 0", obs_we); end
        checks++; if (obs_rdata !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata got %h exp 8899aabb", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", obs_err); end
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", obs_lat); end
        checks++; if (obs_ready_busy !== 1'b0) begin errors++; $display("FAIL lw_ready_busy got %b exp 0", obs_ready_busy); end
    endtask

    task automatic test_load_sub();
        xact(1'b0, 3'b011, 32'h103, 32'h0, 32'h80112233, 32'h0, 1);
        checks++; if (obs_be[0] !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", obs_be[0]); end
        checks++; if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", obs_rdata); end
        xact(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 32'h0, 1);
        checks++; if (obs_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", obs_rdata); end
        xact(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 32'h0, 1);
        checks++; if (obs_be[0] !== 4'b1100) begin errors++; $display("FAIL lh_be got %b exp 1100", obs_be[0]); end
        checks++; if (obs_rdata !== 32'hFFFF8011) begin errors++; $display("FAIL lh_rdata got %h exp ffff8011", obs_rdata); end
        xact(1'b0, 3'b010, 32'h102, 32'h0, 32'h80112233, 32'h0, 1);
        checks++; if (obs_rdata !== 32'h00008011) begin errors++; $display("FAIL lhu_rdata got %h exp 00008011", obs_rdata); end
        xact(1'b0, 3'b011, 32'h101, 32'h0, 32'h80112233, 32'h0, 1);
        checks++; if (obs_rdata !== 32'h00000022) begin errors++; $display("FAIL lb1_rdata got %h exp 00000022", obs_rdata); end
    endtask

    task automatic test_store();
        xact(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 32'h0, 1);
        checks++; if (obs_be[0] !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", obs_be[0]); end
        checks++; if (obs_wdata[0] !== 32'hBEEF0000) begin errors++; $display("FAIL sh_wdata got %h exp beef0000", obs_wdata[0]); end
        checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b exp 1", obs_we); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL sh_err got %b exp 0", obs_err); end
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata got %h exp 0", obs_rdata); end
        xact(1'b1, 3'b100, 32'h101, 32'h000000A5, 32'h0, 32'h0, 1);
        checks++; if (obs_be[0] !== 4'b0010) begin errors++; $display("FAIL sb_be got %b exp 0010", obs_be[0]); end
        checks++; if (obs_wdata[0] !== 32'h0000A500) begin errors++; $display("FAIL sb_wdata got %h exp 0000a500", obs_wdata[0]); end
        xact(1'b1, 3'b000, 32'h200, 32'h12345678, 32'h0, 32'h0, 1);
        checks++; if (obs_be[0] !== 4'b1111 || obs_wdata[0] !== 32'h12345678 || obs_addr[0] !== 32'h200) begin
            errors++; $display("FAIL sw_beat got be %b wdata %h addr %h exp 1111 12345678 00000200",
                               obs_be[0], obs_wdata[0], obs_addr[0]);
        end
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_SPLIT_EN
        xact(1'b0, 3'b000, 32'h101, 32'h0, 32'h44332211, 32'h00000055, 1);
        checks++; if (obs_nbeat != 2) begin errors++; $display("FAIL split_beats got %0d exp 2", obs_nbeat); end
        checks++; if (obs_addr[0] !== 32'h100 || obs_be[0] !== 4'b1110) begin
            errors++; $display("FAIL split_beat0 got %h/%b exp 00000100/1110", obs_addr[0], obs_be[0]); end
        checks++; if (obs_addr[1] !== 32'h104 || obs_be[1] !== 4'b0001) begin
            errors++; $display("FAIL split_beat1 got %h/%b exp 00000104/0001", obs_addr[1], obs_be[1]); end
        checks++; if (obs_rdata !== 32'h55443322 || obs_err !== 1'b0) begin
            errors++; $display("FAIL split_rdata got %h err %b exp 55443322 err 0", obs_rdata, obs_err); end
        xact(1'b0, 3'b001, 32'h0FF, 32'h0, 32'hAA000000, 32'h000000BB, 1);
        checks++; if (obs_be[0] !== 4'b1000 || obs_be[1] !== 4'b0001 || obs_rdata !== 32'hFFFFBBAA) begin
            errors++; $display("FAIL split_lh got be %b %b rdata %h exp 1000 0001 ffffbbaa", obs_be[0], obs_be[1], obs_rdata); end
        xact(1'b1, 3'b000, 32'hFFFFFFFE, 32'hDDCCBBAA, 32'h0, 32'h0, 1);
        checks++; if (obs_addr[0] !== 32'hFFFFFFFC || obs_addr[1] !== 32'h0) begin
            errors++; $display("FAIL split_wrap_addr got %h %h exp fffffffc 00000000", obs_addr[0], obs_addr[1]); end
        checks++; if (obs_wdata[0] !== 32'hBBAA0000 || obs_wdata[1] !== 32'h0000DDCC || obs_be[0] !== 4'b1100 || obs_be[1] !== 4'b0011) begin
            errors++; $display("FAIL split_wrap_data got %h %h be %b %b exp bbaa0000 0000ddcc 1100 0011",
                               obs_wdata[0], obs_wdata[1], obs_be[0], obs_be[1]); end
`else
        xact(1'b0, 3'b000, 32'h101, 32'h0, 32'h44332211, 32'h00000055, 1);
        checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL misalign_lw_err got rsp %b err %b exp 1 1", obs_rsp, obs_err); end
        checks++; if (obs_req_cycles != 0 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL misalign_lw_bus got req_cycles %0d rdata %h exp 0 0", obs_req_cycles, obs_rdata); end
        xact(1'b1, 3'b001, 32'h103, 32'h1234, 32'h0, 32'h0, 1);
        checks++; if (obs_err !== 1'b1 || obs_req_cycles != 0) begin
            errors++; $display("FAIL misalign_sh got err %b req_cycles %0d exp 1 0", obs_err, obs_req_cycles); end
`endif
    endtask

    task automatic test_illegal();
        xact(1'b0, 3'b101, 32'h100, 32'h0, 32'h11111111, 32'h0, 1);
        checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL illegal101 got rsp %b err %b exp 1 1", obs_rsp, obs_err); end
        checks++; if (obs_req_cycles != 0 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL illegal101_bus got req_cycles %0d rdata %h exp 0 0", obs_req_cycles, obs_rdata); end
        xact(1'b1, 3'b111, 32'h100, 32'h0, 32'h0, 32'h0, 1);
        checks++; if (obs_err !== 1'b1 || obs_req_cycles != 0) begin
            errors++; $display("FAIL illegal111 got err %b req_cycles %0d exp 1 0", obs_err, obs_req_cycles); end
    endtask

    task automatic test_timeout();
        xact(1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        checks++; if (obs_rsp !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL timeout_err got rsp %b err %b exp 1 1", obs_rsp, obs_err); end
        checks++; if (obs_req_cycles != 16) begin
            errors++; $display("FAIL timeout_req_cycles got %0d exp 16", obs_req_cycles); end
        checks++; if (obs_req_at_rsp !== 1'b0 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_drop got bus_req %b rdata %h exp 0 0", obs_req_at_rsp, obs_rdata); end
    endtask

    task automatic test_rst_mid();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'b000; req_addr = 32'h300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        bus_gnt = bus_req;
        @(posedge clk);
        #1 bus_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || bus_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state got ready %b bus_req %b exp 1 0", req_ready, bus_req); end
        @(negedge clk);
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (rsp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d pulses exp 0", seen); end
        xact(1'b0, 3'b000, 32'h100, 32'h0, 32'h0BADF00D, 32'h0, 1);
        checks++; if (obs_rdata !== 32'h0BADF00D || obs_err !== 1'b0 || obs_lat != 3) begin
            errors++; $display("FAIL rst_mid_next got rdata %h err %b lat %0d exp 0badf00d 0 3", obs_rdata, obs_err, obs_lat); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misalign();
        test_illegal();
        test_timeout();
        test_rst_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
